// File: rtl/seq_pattern_runner_if.sv
// Host-side bundle for seq_pattern_runner: run request,
// programmed pattern/length and captured trace results.
interface seq_pattern_runner_if #(
  parameter int MAX_LEN = 16,
  parameter int CNT_W   = 5
);
  logic               start;
  logic [MAX_LEN-1:0] pattern;
  logic [CNT_W-1:0]   len;
  logic               busy;
  logic               done;
  logic [MAX_LEN-1:0] capture;
  logic [CNT_W-1:0]   ones_count;

  modport master (
    output start, pattern, len,
    input  busy, done, capture, ones_count
  );

  modport slave (
    input  start, pattern, len,
    output busy, done, capture, ones_count
  );
endinterface

// File: rtl/seq_pattern_runner.sv
// Drives x of a T-flip-flop sequential circuit from a pattern,
// resets it before each run and captures its y output per cycle.
module seq_pattern_runner #(
  parameter int MAX_LEN = 16,
  parameter int CNT_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  seq_pattern_runner_if.slave bus,
  input  logic              y_in,
  output logic              x_out,
  output logic              dut_rst
);
  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    RUN,
    DONE
  } state_t;

  state_t             state;
  logic [MAX_LEN-1:0] pat_q;
  logic [CNT_W-1:0]   len_q;
  logic [IW-1:0]      idx;
  logic [MAX_LEN-1:0] cap_q;
  logic [CNT_W-1:0]   ones_q;
  logic               busy_q;
  logic               done_q;
  logic [CNT_W-1:0]   len_c;
  logic               last;

  assign len_c = (bus.len > CNT_W'(MAX_LEN))
               ? CNT_W'(MAX_LEN) : bus.len;

  assign last = (CNT_W'(idx) == len_q - CNT_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      pat_q  <= '0;
      len_q  <= '0;
      idx    <= '0;
      cap_q  <= '0;
      ones_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            pat_q <= bus.pattern;
            len_q <= len_c;
            if (len_c == '0) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state  <= CLEAR;
              busy_q <= 1'b1;
            end
          end
        end
        CLEAR: begin
          cap_q  <= '0;
          ones_q <= '0;
          idx    <= '0;
          state  <= RUN;
        end
        RUN: begin
          // y_in is the Moore output before this edge's transition
          cap_q[idx] <= y_in;
          ones_q     <= ones_q + CNT_W'(y_in);
          idx        <= idx + 1'b1;
          if (last) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign x_out   = (state == RUN) ? pat_q[idx] : 1'b0;
  assign dut_rst = reset | (state == CLEAR);

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.capture    = cap_q;
  assign bus.ones_count = ones_q;
endmodule

// File: tb/tb_seq_pattern_runner.sv
// Scoreboard bench: T-FF circuit under control, integer reference
// model per run, monitor checks trace/count/latency on each done.
module tb_seq_pattern_runner;
  logic clk;
  logic reset;
  logic y_in;
  logic x_out;
  logic dut_rst;

  seq_pattern_runner_if #(.MAX_LEN(16), .CNT_W(5)) bif ();

  seq_pattern_runner #(.MAX_LEN(16), .CNT_W(5)) u_dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bif),
    .y_in    (y_in),
    .x_out   (x_out),
    .dut_rst (dut_rst)
  );

  // controlled circuit: tA=~A&x|B&~x, tB=A&~B|~A&x, y=A^B
  logic ca, cb;
  always_ff @(posedge clk or posedge dut_rst) begin
    if (dut_rst) begin
      ca <= 1'b0;
      cb <= 1'b0;
    end else begin
      ca <= ca ^ ((~ca & x_out) | (cb & ~x_out));
      cb <= cb ^ ((ca & ~cb) | (~ca & x_out));
    end
  end
  assign y_in = ca ^ cb;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] cap;
    int          ones;
    int          lat;
    int          t0;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] last_cap = '0;
  int          last_ones = 0;
  logic        rst_seen = 1'b0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference: walk the circuit's state bit by bit with plain integers
  function automatic void ref_run(input logic [15:0] p, input int l,
                                  output logic [15:0] cap,
                                  output int ones, output int n);
    int a, b, x, y, na, nb;
    n = (l > 16) ? 16 : l;
    cap = '0;
    ones = 0;
    a = 0;
    b = 0;
    for (int i = 0; i < n; i++) begin
      x = int'(p[i]);
      y = a ^ b;
      cap[i] = y[0];
      ones += y;
      na = a ^ (((1 - a) & x) | (b & (1 - x)));
      nb = b ^ ((a & (1 - b)) | ((1 - a) & x));
      a = na;
      b = nb;
    end
  endfunction

  task automatic expect_run(logic [15:0] p, int l, int t0);
    exp_t        e;
    logic [15:0] c;
    int          o, n;
    ref_run(p, l, c, o, n);
    if (n == 0) begin
      e.cap  = last_cap;
      e.ones = last_ones;
      e.lat  = 1;
    end else begin
      e.cap     = c;
      e.ones    = o;
      e.lat     = n + 2;
      last_cap  = c;
      last_ones = o;
    end
    e.t0 = t0;
    q.push_back(e);
  endtask

  // latency counts edges from the start edge to the edge sampling done
  always @(negedge clk) begin
    exp_t e;
    if (!reset && bif.done) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1 want none");
      end else begin
        e = q.pop_front();
        chk("capture", 32'(bif.capture), 32'(e.cap));
        chk("ones_count", 32'(bif.ones_count), 32'(e.ones));
        chk("latency", 32'(cyc - e.t0 + 1), 32'(e.lat));
      end
    end
    if (!reset && dut_rst) rst_seen <= 1'b1;
  end

  task automatic run(logic [15:0] p, int l);
    @(negedge clk);
    bif.pattern = p;
    bif.len     = 5'(l);
    bif.start   = 1'b1;
    expect_run(p, l, cyc + 1);
    @(negedge clk);
    bif.start   = 1'b0;
    bif.pattern = 16'($urandom);
    bif.len     = 5'($urandom);
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (q.size() == 0 && !bif.done && !bif.busy) break;
    end
    chk("idle_reached", 32'(k < 300), 32'(1));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] p;
    int          cd, cr;

    reset       = 1'b1;
    bif.start   = 1'b0;
    bif.pattern = '0;
    bif.len     = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_dut_rst", 32'(dut_rst), 32'(1));
    chk("rst_busy", 32'(bif.busy), 32'(0));
    reset = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(bif.busy), 32'(0));
    chk("idle_done", 32'(bif.done), 32'(0));
    chk("idle_capture", 32'(bif.capture), 32'(0));
    chk("idle_ones", 32'(bif.ones_count), 32'(0));
    chk("idle_dut_rst", 32'(dut_rst), 32'(0));
    chk("idle_x_out", 32'(x_out), 32'(0));

    run(16'h0003, 4);
    wait_idle();
    chk("dir_capture", 32'(bif.capture), 32'h0008);
    chk("dir_ones", 32'(bif.ones_count), 32'(1));

    rst_seen = 1'b0;
    run(16'h5A5A, 0);
    wait_idle();
    chk("empty_no_clear", 32'(rst_seen), 32'(0));
    chk("empty_capture", 32'(bif.capture), 32'h0008);

    run(16'hFFFF, 31);
    wait_idle();

    p = 16'($urandom);
    run(p, 6);
    @(negedge clk);
    @(negedge clk);
    bif.pattern = ~p;
    bif.len     = 5'd9;
    bif.start   = 1'b1;
    @(negedge clk);
    bif.start   = 1'b0;
    wait_idle();

    // start held high: two runs, one IDLE cycle between them
    p = 16'($urandom);
    @(negedge clk);
    bif.pattern = p;
    bif.len     = 5'd3;
    bif.start   = 1'b1;
    expect_run(p, 3, cyc + 1);
    expect_run(p, 3, cyc + 1 + 3 + 3);
    cd = -1;
    cr = -1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (bif.done && cd < 0) cd = cyc;
      else if (cd >= 0 && dut_rst) begin
        cr = cyc;
        break;
      end
    end
    bif.start = 1'b0;
    chk("held_gap", 32'(cr - cd), 32'(2));
    wait_idle();

    for (int i = 0; i < 24; i++) begin
      run(16'($urandom), int'($urandom_range(0, 31)));
      wait_idle();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    run(16'($urandom), 8);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("mid_busy_pre", 32'(bif.busy), 32'(1));
    q.delete();
    reset = 1'b1;
    #1;
    chk("mid_busy", 32'(bif.busy), 32'(0));
    chk("mid_capture", 32'(bif.capture), 32'(0));
    chk("mid_ones", 32'(bif.ones_count), 32'(0));
    chk("mid_dut_rst", 32'(dut_rst), 32'(1));
    chk("mid_done", 32'(bif.done), 32'(0));
    last_cap  = '0;
    last_ones = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    run(16'($urandom), 16);
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
